tm1637_ctrl: RTL and testbench

TM1637_CTRL -- requirements
Module: tm1637_ctrl

---
 rtl/tm1637_ctrl.sv | 157 +++++++++++++++
 tb/tb_tm1637_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/tm1637_ctrl.sv
// TM1637 frame sequencer: sends the data command, the address command, the digit
// bytes and the display-control byte to an external byte writer, one latch per byte.
module tm1637_ctrl #(
  parameter int NUM_DIGITS    = 4,
  parameter bit INIT_ON_RESET = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    update,
  input  logic [8*NUM_DIGITS-1:0] digits,
  input  logic [2:0]              brightness,
  input  logic                    display_on,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    wr_latch,
  output logic [7:0]              wr_byte,
  output logic                    wr_stop,
  input  logic                    wr_busy
);

  localparam int LAST = NUM_DIGITS + 2;
  localparam int KW   = $clog2(NUM_DIGITS + 3);
  localparam int TAB  = 1 << KW;
  localparam logic [KW-1:0] K_LAST = KW'(LAST);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACC, WAIT_DONE} state_t;

  state_t                  state_reg, state_next;
  logic [KW-1:0]           k_reg, k_next;
  logic                    pending_reg, pending_next;
  logic                    started_reg, started_next;
  logic                    busy_reg, busy_next;
  logic                    done_reg, done_next;
  logic                    latch_reg, latch_next;
  logic [7:0]              byte_reg, byte_next;
  logic                    stop_reg, stop_next;
  logic [8*NUM_DIGITS-1:0] dig_snap_reg, dig_snap_next;
  logic [2:0]              bright_snap_reg, bright_snap_next;
  logic                    on_snap_reg, on_snap_next;

  // Byte/stop lookup for every frame index, built from the snapshot only.
  logic [7:0]     byte_tab [TAB];
  logic [TAB-1:0] stop_tab;

  genvar gi;
  generate
    for (gi = 0; gi < TAB; gi++) begin : g_tab
      if (gi == 0) begin : g_data_cmd
        assign byte_tab[gi] = 8'h40;
        assign stop_tab[gi] = 1'b1;
      end else if (gi == 1) begin : g_addr_cmd
        assign byte_tab[gi] = 8'hC0;
        assign stop_tab[gi] = 1'b0;
      end else if (gi < LAST) begin : g_digit
        assign byte_tab[gi] = dig_snap_reg[8*(gi-2) +: 8];
        assign stop_tab[gi] = (gi == LAST - 1);
      end else if (gi == LAST) begin : g_ctrl
        assign byte_tab[gi] = {4'b1000, on_snap_reg, bright_snap_reg};
        assign stop_tab[gi] = 1'b1;
      end else begin : g_unused
        assign byte_tab[gi] = 8'h00;
        assign stop_tab[gi] = 1'b0;
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      k_reg           <= '0;
      pending_reg     <= 1'b0;
      started_reg     <= 1'b0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      latch_reg       <= 1'b0;
      byte_reg        <= 8'h00;
      stop_reg        <= 1'b0;
      dig_snap_reg    <= '0;
      bright_snap_reg <= 3'd0;
      on_snap_reg     <= 1'b0;
    end else begin
      state_reg       <= state_next;
      k_reg           <= k_next;
      pending_reg     <= pending_next;
      started_reg     <= started_next;
      busy_reg        <= busy_next;
      done_reg        <= done_next;
      latch_reg       <= latch_next;
      byte_reg        <= byte_next;
      stop_reg        <= stop_next;
      dig_snap_reg    <= dig_snap_next;
      bright_snap_reg <= bright_snap_next;
      on_snap_reg     <= on_snap_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    k_next           = k_reg;
    pending_next     = pending_reg | update;
    started_next     = 1'b1;
    busy_next        = busy_reg;
    done_next        = 1'b0;
    latch_next       = 1'b0;
    byte_next        = byte_reg;
    stop_next        = stop_reg;
    dig_snap_next    = dig_snap_reg;
    bright_snap_next = bright_snap_reg;
    on_snap_next     = on_snap_reg;

    case (state_reg)
      IDLE: begin
        // A start request in the same cycle as the power-up request covers both.
        if (update || pending_reg) begin
          dig_snap_next    = digits;
          bright_snap_next = brightness;
          on_snap_next     = display_on;
          k_next           = '0;
          busy_next        = 1'b1;
          pending_next     = 1'b0;
          state_next       = ISSUE;
        end else begin
          pending_next = INIT_ON_RESET && !started_reg;
        end
      end
      ISSUE: begin
        latch_next = 1'b1;
        byte_next  = byte_tab[k_reg];
        stop_next  = stop_tab[k_reg];
        state_next = WAIT_ACC;
      end
      WAIT_ACC: begin
        if (wr_busy) state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!wr_busy) begin
          if (k_reg == K_LAST) begin
            done_next  = 1'b1;
            busy_next  = 1'b0;
            state_next = IDLE;
          end else begin
            k_next     = k_reg + KW'(1);
            state_next = ISSUE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy       = busy_reg;
  assign frame_done = done_reg;
  assign wr_latch   = latch_reg;
  assign wr_byte    = byte_reg;
  assign wr_stop    = stop_reg;

endmodule

// File: tb/tb_tm1637_ctrl.sv
// Scoreboard bench for tm1637_ctrl: a 4-digit auto-start instance and a 6-digit
// update-only instance, each driving a modelled byte writer.
module tb_tm1637_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Instance A: NUM_DIGITS=4, INIT_ON_RESET=1
  logic        rst_a_n, upd_a, on_a, busy_a, done_a, lat_a, stop_a, wb_a;
  logic [31:0] dig_a;
  logic [2:0]  br_a;
  logic [7:0]  byte_a;
  // Instance B: NUM_DIGITS=6, INIT_ON_RESET=0
  logic        rst_b_n, upd_b, on_b, busy_b, done_b, lat_b, stop_b, wb_b;
  logic [47:0] dig_b;
  logic [2:0]  br_b;
  logic [7:0]  byte_b;

  tm1637_ctrl #(.NUM_DIGITS(4), .INIT_ON_RESET(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_a_n), .update(upd_a), .digits(dig_a), .brightness(br_a),
    .display_on(on_a), .busy(busy_a), .frame_done(done_a), .wr_latch(lat_a),
    .wr_byte(byte_a), .wr_stop(stop_a), .wr_busy(wb_a)
  );

  tm1637_ctrl #(.NUM_DIGITS(6), .INIT_ON_RESET(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_b_n), .update(upd_b), .digits(dig_b), .brightness(br_b),
    .display_on(on_b), .busy(busy_b), .frame_done(done_b), .wr_latch(lat_b),
    .wr_byte(byte_b), .wr_stop(stop_b), .wr_busy(wb_b)
  );

  // Byte writer: busy rises the cycle after a latch and stays high 20 cycles.
  int cnt_a, cnt_b;
  always @(posedge clk or negedge rst_a_n) begin
    if (!rst_a_n) begin
      wb_a <= 1'b0; cnt_a <= 0;
    end else if (lat_a) begin
      wb_a <= 1'b1; cnt_a <= 19;
    end else if (cnt_a > 0) cnt_a <= cnt_a - 1;
    else wb_a <= 1'b0;
  end
  always @(posedge clk or negedge rst_b_n) begin
    if (!rst_b_n) begin
      wb_b <= 1'b0; cnt_b <= 0;
    end else if (lat_b) begin
      wb_b <= 1'b1; cnt_b <= 19;
    end else if (cnt_b > 0) cnt_b <= cnt_b - 1;
    else wb_b <= 1'b0;
  end

  logic [8:0] q_a[$];
  logic [8:0] q_b[$];
  int nlat_a = 0, ndone_a = 0, nlat_b = 0, ndone_b = 0;

  always @(negedge clk) begin
    logic [8:0] e;
    if (lat_a) begin
      nlat_a++;
      if (q_a.size() == 0) check("a_unexpected_latch", lat_a, 0);
      else begin
        e = q_a.pop_front();
        check("a_byte", {stop_a, byte_a}, e);
        $display("A byte %0d: stop=%0b byte=0x%02h", nlat_a, stop_a, byte_a);
      end
    end
    if (done_a) ndone_a++;
    if (lat_b) begin
      nlat_b++;
      if (q_b.size() == 0) check("b_unexpected_latch", lat_b, 0);
      else begin
        e = q_b.pop_front();
        check("b_byte", {stop_b, byte_b}, e);
        $display("B byte %0d: stop=%0b byte=0x%02h", nlat_b, stop_b, byte_b);
      end
    end
    if (done_b) ndone_b++;
  end

  task automatic push_frame(input bit to_b, input logic [47:0] d, input int nd,
                            input logic [2:0] br, input logic on);
    logic [8:0] e;
    for (int k = 0; k < nd + 3; k++) begin
      if (k == 0) e = {1'b1, 8'h40};
      else if (k == 1) e = {1'b0, 8'hC0};
      else if (k <= nd + 1) e = {(k == nd + 1), d[8*(k-2) +: 8]};
      else e = {1'b1, 4'h8, on, br};
      if (to_b) q_b.push_back(e);
      else q_a.push_back(e);
    end
  endtask

  // sel: 0 = frames done on A, 1 = frames done on B, 2 = latches on A
  task automatic wait_cnt(input string tag, input int sel, input int target);
    int v;
    v = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      v = (sel == 0) ? ndone_a : (sel == 1) ? ndone_b : nlat_a;
      if (v >= target) return;
    end
    check(tag, v, target);
  endtask

  task automatic pulse_a();
    @(negedge clk); upd_a = 1'b1;
    @(negedge clk); upd_a = 1'b0;
  endtask

  int base, d0;

  initial begin
    rst_a_n = 1'b0; rst_b_n = 1'b0; upd_a = 1'b0; upd_b = 1'b0;
    dig_a = 32'h3F06_5B4F; br_a = 3'd7; on_a = 1'b1;
    dig_b = 48'hA1B2_C3D4_E5F6; br_b = 3'd3; on_b = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", busy_a, 0);
    check("rst_latch", lat_a, 0);
    check("rst_byte", byte_a, 0);
    check("rst_stop", stop_a, 0);
    check("rst_done", done_a, 0);
    check("rst_b_busy", busy_b, 0);

    // Auto-start frame carries the basic pattern: 40 C0 4F 5B 06 3F 8F
    push_frame(1'b0, {16'h0, dig_a}, 4, br_a, on_a);
    rst_a_n = 1'b1; rst_b_n = 1'b1;
    wait_cnt("init_frame_timeout", 0, 1);
    check("init_queue_left", q_a.size(), 0);
    repeat (40) @(negedge clk);
    check("noinit_b_busy", busy_b, 0);
    check("noinit_b_latches", nlat_b, 0);

    // Update latency, display off and snapshot hold
    dig_a = 32'h1122_3344; br_a = 3'd2; on_a = 1'b0;
    push_frame(1'b0, {16'h0, dig_a}, 4, br_a, on_a);
    base = nlat_a;
    @(negedge clk); upd_a = 1'b1;
    @(posedge clk); #1;
    check("lat_busy_after_accept", busy_a, 1);
    check("lat_no_latch_yet", lat_a, 0);
    upd_a = 1'b0;
    @(posedge clk); #1;
    check("lat_first_latch", lat_a, 1);
    wait_cnt("snap_wait_timeout", 2, base + 3);
    dig_a = 32'hDEAD_BEEF; br_a = 3'd5; on_a = 1'b1;
    wait_cnt("snap_frame_timeout", 0, 2);
    check("snap_queue_left", q_a.size(), 0);

    // Coalescing: three requests mid-frame -> one more frame with restart-time inputs
    dig_a = 32'h0102_0304; br_a = 3'd4; on_a = 1'b1;
    push_frame(1'b0, {16'h0, dig_a}, 4, br_a, on_a);
    d0 = ndone_a; base = nlat_a;
    pulse_a();
    wait_cnt("coal_wait_timeout", 2, base + 2);
    pulse_a(); repeat (5) @(negedge clk);
    pulse_a(); repeat (30) @(negedge clk);
    pulse_a();
    dig_a = 32'h5566_7788; br_a = 3'd1; on_a = 1'b0;
    push_frame(1'b0, {16'h0, dig_a}, 4, br_a, on_a);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done_a) break;
    end
    check("coal_done_seen", done_a, 1);
    check("coal_gap_busy", busy_a, 0);
    @(negedge clk);
    check("coal_restart_busy", busy_a, 1);
    wait_cnt("coal_frame_timeout", 0, d0 + 2);
    repeat (100) @(negedge clk);
    check("coal_idle_busy", busy_a, 0);
    check("coal_frame_count", ndone_a, d0 + 2);
    check("coal_queue_left", q_a.size(), 0);

    // Reset during byte 3 abandons the frame; auto-start sends current inputs
    dig_a = 32'hCAFE_F00D; br_a = 3'd6; on_a = 1'b1;
    push_frame(1'b0, {16'h0, dig_a}, 4, br_a, on_a);
    d0 = ndone_a; base = nlat_a;
    pulse_a();
    wait_cnt("rst_wait_timeout", 2, base + 4);
    repeat (3) @(negedge clk);
    #2 rst_a_n = 1'b0;
    #1;
    check("midrst_busy", busy_a, 0);
    check("midrst_latch", lat_a, 0);
    check("midrst_byte", byte_a, 0);
    check("midrst_stop", stop_a, 0);
    check("midrst_done", done_a, 0);
    q_a.delete();
    repeat (3) @(negedge clk);
    dig_a = 32'h0BAD_C0DE;
    push_frame(1'b0, {16'h0, dig_a}, 4, br_a, on_a);
    rst_a_n = 1'b1;
    wait_cnt("rst_frame_timeout", 0, d0 + 1);
    repeat (50) @(negedge clk);
    check("rst_frame_count", ndone_a, d0 + 1);
    check("rst_queue_left", q_a.size(), 0);

    // Six digits: nine bytes, stop on byte 7, control byte last
    push_frame(1'b1, dig_b, 6, br_b, on_b);
    @(negedge clk); upd_b = 1'b1;
    @(negedge clk); upd_b = 1'b0;
    wait_cnt("b_frame_timeout", 1, 1);
    repeat (10) @(negedge clk);
    check("b_latch_count", nlat_b, 9);
    check("b_queue_left", q_b.size(), 0);
    check("b_idle_busy", busy_b, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
